// File: rtl/pixel_seq_ctrl.sv
// Burst sequencer for the pixel FSM: runs N start/done/ack handshakes and
// accumulates the samples, with a per-phase timeout and host abort.
module pixel_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 4095,
    parameter int unsigned CNT_W       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start_i,
    input  logic        cmd_abort_i,
    input  logic [7:0]  cfg_num_frames,
    input  logic [9:0]  cfg_loc_max_clk,
    input  logic [9:0]  cfg_adj_max_clk,
    input  logic        cfg_loc_mode,
    input  logic        cfg_adj_mode,
    input  logic        cfg_data_in,
    output logic        pxl_start_o,
    output logic        pxl_ack_o,
    output logic        loc_timer_m_o,
    output logic        adj_timer_m_o,
    output logic        data_in_o,
    output logic [9:0]  loc_max_clk_o,
    output logic [9:0]  adj_max_clk_o,
    input  logic        pxl_done_i,
    input  logic [15:0] pxl_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic        aborted_o,
    output logic [7:0]  frame_cnt_o,
    output logic [15:0] result_o,
    output logic        result_valid_o,
    output logic [23:0] acc_o
);

    localparam int unsigned FRM_W = 8;
    localparam int unsigned CLK_W = 10;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned ACC_W = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_DONE, S_CAPTURE, S_ACK, S_NEXT, S_FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRM_W-1:0]   num_q, num_d;
    logic [CLK_W-1:0]   loc_max_q, loc_max_d, adj_max_q, adj_max_d;
    logic               loc_mode_q, loc_mode_d, adj_mode_q, adj_mode_d;
    logic               data_in_q, data_in_d;
    logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [DAT_W-1:0]   result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               aborted_q, aborted_d;
    logic               busy_q, busy_d;
    logic               pxl_start_q, pxl_start_d;
    logic               pxl_ack_q, pxl_ack_d;
    logic               abort_c;

    assign abort_c = cmd_abort_i && (state_q != S_IDLE) && (state_q != S_FINISH);

    // Next-state, datapath updates and registered-output decode
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        num_d          = num_q;
        loc_max_d      = loc_max_q;
        adj_max_d      = adj_max_q;
        loc_mode_d     = loc_mode_q;
        adj_mode_d     = adj_mode_q;
        data_in_d      = data_in_q;
        frame_cnt_d    = frame_cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        acc_d          = acc_q;
        done_d         = 1'b0;
        timeout_d      = timeout_q;
        aborted_d      = aborted_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_start_i && !cmd_abort_i) begin
                    if (cfg_num_frames != '0) begin
                        num_d       = cfg_num_frames;
                        loc_max_d   = cfg_loc_max_clk;
                        adj_max_d   = cfg_adj_max_clk;
                        loc_mode_d  = cfg_loc_mode;
                        adj_mode_d  = cfg_adj_mode;
                        data_in_d   = cfg_data_in;
                        frame_cnt_d = '0;
                        acc_d       = '0;
                        timeout_d   = 1'b0;
                        aborted_d   = 1'b0;
                        state_d     = S_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: state_d = S_START;
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (pxl_done_i) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                result_d       = pxl_data_i;
                result_valid_d = 1'b1;
                acc_d          = acc_q + ACC_W'(pxl_data_i);
                frame_cnt_d    = frame_cnt_q + FRM_W'(1);
                cnt_d          = '0;
                state_d        = S_ACK;
            end
            S_ACK: begin
                if (!pxl_done_i) begin
                    state_d = S_NEXT;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_NEXT: state_d = (frame_cnt_q == num_q) ? S_FINISH : S_START;
            S_FINISH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any same-cycle capture or timeout
        if (abort_c) begin
            state_d        = S_FINISH;
            aborted_d      = 1'b1;
            timeout_d      = timeout_q;
            cnt_d          = cnt_q;
            result_d       = result_q;
            result_valid_d = 1'b0;
            acc_d          = acc_q;
            frame_cnt_d    = frame_cnt_q;
        end

        pxl_start_d = (state_d == S_START);
        pxl_ack_d   = (state_d == S_ACK);
        busy_d      = (state_d != S_IDLE);
        if (state_d == S_FINISH) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            num_q          <= '0;
            loc_max_q      <= '0;
            adj_max_q      <= '0;
            loc_mode_q     <= 1'b0;
            adj_mode_q     <= 1'b0;
            data_in_q      <= 1'b0;
            frame_cnt_q    <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            acc_q          <= '0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            aborted_q      <= 1'b0;
            busy_q         <= 1'b0;
            pxl_start_q    <= 1'b0;
            pxl_ack_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            num_q          <= num_d;
            loc_max_q      <= loc_max_d;
            adj_max_q      <= adj_max_d;
            loc_mode_q     <= loc_mode_d;
            adj_mode_q     <= adj_mode_d;
            data_in_q      <= data_in_d;
            frame_cnt_q    <= frame_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            acc_q          <= acc_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
            aborted_q      <= aborted_d;
            busy_q         <= busy_d;
            pxl_start_q    <= pxl_start_d;
            pxl_ack_q      <= pxl_ack_d;
        end
    end

    assign pxl_start_o    = pxl_start_q;
    assign pxl_ack_o      = pxl_ack_q;
    assign loc_timer_m_o  = loc_mode_q;
    assign adj_timer_m_o  = adj_mode_q;
    assign data_in_o      = data_in_q;
    assign loc_max_clk_o  = loc_max_q;
    assign adj_max_clk_o  = adj_max_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign timeout_o      = timeout_q;
    assign aborted_o      = aborted_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign acc_o          = acc_q;

endmodule
